// File: rtl/seq_shifter.sv
// Multi-cycle shifter (SLL/SRL/SRA/ROTR). It moves at most STEP bits per cycle.
// It uses a valid/ready handshake on both the request side and the result side.
module seq_shifter #(
  parameter int WIDTH   = 32,
  parameter int STEP    = 4,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_amt,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {
    MODE_SLL  = 2'b00,
    MODE_SRL  = 2'b01,
    MODE_SRA  = 2'b10,
    MODE_ROTR = 2'b11
  } mode_t;

  // One extra bit so that STEP == WIDTH is still representable.
  localparam logic [SHAMT_W:0] STEP_EXT = (SHAMT_W+1)'(STEP);

  state_t             state_q, state_d;
  mode_t              mode_q, mode_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic               sign_q, sign_d;

  logic [SHAMT_W-1:0] step_amt;
  logic [SHAMT_W-1:0] step_neg;
  logic [WIDTH-1:0]   shifted;

  always_comb begin
    step_amt = STEP_EXT[SHAMT_W-1:0];
    if ({1'b0, rem_q} < STEP_EXT) begin
      step_amt = rem_q;
    end
    // WIDTH is a power of two, so the value -k modulo WIDTH equals WIDTH-k.
    step_neg = '0 - step_amt;
  end

  // SRA fills from the sign bit that was latched at accept time.
  // It does not use the current MSB of the working register.
  always_comb begin
    shifted = work_q;
    case (mode_q)
      MODE_SLL:  shifted = work_q << step_amt;
      MODE_SRL:  shifted = work_q >> step_amt;
      MODE_SRA:  shifted = (work_q >> step_amt) |
                           (sign_q ? ~({WIDTH{1'b1}} >> step_amt) : '0);
      MODE_ROTR: shifted = (work_q >> step_amt) | (work_q << step_neg);
      default:   shifted = work_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    work_d  = work_q;
    rem_d   = rem_q;
    sign_d  = sign_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          rem_d   = in_amt;
          mode_d  = mode_t'(in_mode);
          sign_d  = in_data[WIDTH-1];
          state_d = (in_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        work_d = shifted;
        rem_d  = rem_q - step_amt;
        if (rem_q == step_amt) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_SLL;
      work_q  <= '0;
      rem_q   <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      sign_q  <= sign_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = work_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter at WIDTH=32 and STEP=4.
// A reference model pushes the expected results into a scoreboard.
module tb_seq_shifter;

  localparam int WIDTH   = 32;
  localparam int STEP    = 4;
  localparam int SHAMT_W = 5;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_amt;
  logic [1:0]         in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               busy;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q[$];
  int               lat_q[$];

  seq_shifter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // The model computes the whole shift in one step, independently of the DUT's stepping.
  function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d,
                                                 input logic [SHAMT_W-1:0] a,
                                                 input logic [1:0] m);
    logic signed [WIDTH-1:0] s;
    int ai;
    s  = d;
    ai = int'(a);
    case (m)
      2'b00:   return d << ai;
      2'b01:   return d >> ai;
      2'b10:   return s >>> ai;
      default: return (ai == 0) ? d : ((d >> ai) | (d << (WIDTH - ai)));
    endcase
  endfunction

  function automatic int ref_lat(input logic [SHAMT_W-1:0] a);
    return 1 + (int'(a) + STEP - 1) / STEP;
  endfunction

  task automatic send_req(input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] a,
                          input logic [1:0] m);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1; in_data = d; in_amt = a; in_mode = m;
    exp_q.push_back(ref_shift(d, a, m));
    lat_q.push_back(ref_lat(a));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts cycles from the accept edge until out_valid is sampled high.
  task automatic wait_out(output int cyc, output bit timed_out);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    timed_out = !out_valid;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    total++; if (out_data !== 32'h0) begin bad++; $display("[TB] FAIL reset_out_data got=%h want=0", out_data); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sll_basic();
    int cyc; bit to; logic [WIDTH-1:0] e; int el;
    out_ready = 1'b1;
    send_req(32'h0000_0001, 5'd2, 2'b00);
    wait_out(cyc, to);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    total++; if (to) begin bad++; $display("[TB] FAIL sll_timeout got=none want=out_valid"); end
    total++; if (out_data !== e) begin bad++; $display("[TB] FAIL sll_data got=%h want=%h", out_data, e); end
    total++; if (cyc !== el) begin bad++; $display("[TB] FAIL sll_latency got=%0d want=%0d", cyc, el); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL sll_return_idle got=%b%b want=10", in_ready, out_valid);
    end
  endtask

  task automatic test_modes();
    logic [WIDTH-1:0]   d_tab[4] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_00F1, 32'hFFFF_FFFF};
    logic [SHAMT_W-1:0] a_tab[4] = '{5'd31, 5'd31, 5'd4, 5'd0};
    logic [1:0]         m_tab[4] = '{2'b10, 2'b01, 2'b11, 2'b00};
    for (int i = 0; i < 4; i++) begin
      int cyc; bit to; logic [WIDTH-1:0] e; int el;
      send_req(d_tab[i], a_tab[i], m_tab[i]);
      wait_out(cyc, to);
      e = exp_q.pop_front(); el = lat_q.pop_front();
      total++; if (to) begin bad++; $display("[TB] FAIL mode%0d_timeout got=none want=out_valid", i); end
      total++; if (out_data !== e) begin bad++; $display("[TB] FAIL mode%0d_data got=%h want=%h", i, out_data, e); end
      total++; if (cyc !== el) begin bad++; $display("[TB] FAIL mode%0d_latency got=%0d want=%0d", i, cyc, el); end
      take_result();
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit to; logic [WIDTH-1:0] e; int el;
    send_req(32'h0F0F_0F0F, 5'd12, 2'b00);
    wait_out(cyc, to);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    total++; if (to) begin bad++; $display("[TB] FAIL bp_timeout got=none want=out_valid"); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (out_data !== e) begin bad++; $display("[TB] FAIL bp_hold%0d got=%h want=%h", i, out_data, e); end
      total++; if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1) begin
        bad++; $display("[TB] FAIL bp_flags%0d got=%b%b%b want=011", i, in_ready, busy, out_valid);
      end
    end
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'hA5A5_0000; in_amt = 5'd8; in_mode = 2'b01;
    exp_q.push_back(ref_shift(32'hA5A5_0000, 5'd8, 2'b01));
    lat_q.push_back(ref_lat(5'd8));
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL b2b_idle got=%b%b want=10", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_accept got=%b want=1", busy); end
    wait_out(cyc, to);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    total++; if (out_data !== e) begin bad++; $display("[TB] FAIL b2b_data got=%h want=%h", out_data, e); end
    total++; if (cyc !== el) begin bad++; $display("[TB] FAIL b2b_latency got=%0d want=%0d", cyc, el); end
    take_result();
  endtask

  task automatic test_ignore_busy();
    int cyc; bit to; logic [WIDTH-1:0] e; int el;
    send_req(32'h1234_5678, 5'd8, 2'b01);
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_amt = 5'd31; in_mode = 2'b11;
    wait_out(cyc, to);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    total++; if (out_data !== 32'h0012_3456 || out_data !== e) begin
      bad++; $display("[TB] FAIL ign_data got=%h want=%h", out_data, e);
    end
    total++; if (cyc !== el) begin bad++; $display("[TB] FAIL ign_latency got=%0d want=%0d", cyc, el); end
    in_data = 32'h0000_0003; in_amt = 5'd3; in_mode = 2'b00;
    exp_q.push_back(ref_shift(32'h3, 5'd3, 2'b00));
    lat_q.push_back(ref_lat(5'd3));
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || out_data !== e) begin
      bad++; $display("[TB] FAIL ign_no_accept_done got=%b/%h want=1/%h", out_valid, out_data, e);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL ign_idle got=%b want=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(cyc, to);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    total++; if (to || out_data !== e) begin bad++; $display("[TB] FAIL ign_held_req got=%h want=%h", out_data, e); end
    total++; if (cyc !== el) begin bad++; $display("[TB] FAIL ign_held_latency got=%0d want=%0d", cyc, el); end
    take_result();
  endtask

  task automatic test_reset_mid_shift();
    int cyc; bit to; logic [WIDTH-1:0] e; int el;
    send_req(32'h0000_0001, 5'd31, 2'b00);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete(); lat_q.delete();
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL async_reset got=%b%b%b want=010", out_valid, in_ready, busy);
    end
    total++; if (out_data !== 32'h0) begin bad++; $display("[TB] FAIL async_reset_data got=%h want=0", out_data); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_req(32'h0000_0001, 5'd1, 2'b00);
    wait_out(cyc, to);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    total++; if (to || out_data !== e) begin bad++; $display("[TB] FAIL post_reset_data got=%h want=%h", out_data, e); end
    total++; if (cyc !== el) begin bad++; $display("[TB] FAIL post_reset_latency got=%0d want=%0d", cyc, el); end
    take_result();
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      int cyc; bit to; logic [WIDTH-1:0] e; int el;
      send_req(WIDTH'($urandom), SHAMT_W'($urandom_range(0, WIDTH-1)), 2'($urandom_range(0, 3)));
      wait_out(cyc, to);
      e = exp_q.pop_front(); el = lat_q.pop_front();
      total++; if (to || out_data !== e) begin bad++; $display("[TB] FAIL rand%0d_data got=%h want=%h", i, out_data, e); end
      total++; if (cyc !== el) begin bad++; $display("[TB] FAIL rand%0d_latency got=%0d want=%0d", i, cyc, el); end
      take_result();
    end
  endtask

  initial begin
    test_reset();
    test_sll_basic();
    test_modes();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid_shift();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
